// File: rtl/elastic_arith_pipeline.sv
// Three-stage elastic pipeline computing F = ((A+B) + (C-D)) * D.
// Valid/ready handshake on both ends; each stage stalls only when full and blocked.
module elastic_arith_pipeline #(
  parameter  int W     = 10,
  localparam int OUT_W = 2 * W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  input  logic [W-1:0]     D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] F,
  output logic             busy
);

  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  logic [W-1:0]     r_x1;
  logic [W-1:0]     r_x2;
  logic [W-1:0]     r_d1;
  logic [W-1:0]     r_x3;
  logic [W-1:0]     r_d2;
  logic [OUT_W-1:0] r_f;

  logic w_ld1;
  logic w_ld2;
  logic w_ld3;
  logic w_acc;

  // Load enables ripple back from the output, so a drain frees the input at once.
  assign w_ld3 = !r_v3 || out_ready;
  assign w_ld2 = !r_v2 || w_ld3;
  assign w_ld1 = !r_v1 || w_ld2;

  assign in_ready  = w_ld1 && !flush;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_v3;
  assign F         = r_f;
  assign busy      = r_v1 || r_v2 || r_v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_d1 <= '0;
    end else if (flush) begin
      r_v1 <= 1'b0;
    end else if (w_ld1) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_x1 <= A + B;
        r_x2 <= C - D;
        r_d1 <= D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_x3 <= '0;
      r_d2 <= '0;
    end else if (flush) begin
      r_v2 <= 1'b0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_x3 <= r_x1 + r_x2;
        r_d2 <= r_d1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3 <= 1'b0;
      r_f  <= '0;
    end else if (flush) begin
      r_v3 <= 1'b0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_f <= OUT_W'(r_x3) * OUT_W'(r_d2);
      end
    end
  end

endmodule

// File: tb/tb_elastic_arith_pipeline.sv
// Bench for elastic_arith_pipeline: vector table, scoreboard queue,
// and hand-written latency, backpressure, flush and async-reset sequences.
module tb_elastic_arith_pipeline;

  localparam int W  = 10;
  localparam int OW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A, B, C, D;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] F;
  logic          busy;

  elastic_arith_pipeline #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .F        (F),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a, b, c, d;
    logic [OW-1:0] f;
  } vec_t;

  vec_t          tab [8];
  logic [OW-1:0] q [$];
  int            checks = 0;
  int            errors = 0;
  int            nacc = 0;
  int            npop = 0;
  int            run = 0;
  int            maxrun = 0;
  bit            prevpop = 0;
  bit            use_tab = 0;
  logic [OW-1:0] tab_f;
  logic [OW-1:0] hold_f;
  int            a0, p0;

  function automatic logic [OW-1:0] ref_f(
    input logic [W-1:0] a, b, c, d);
    logic [W-1:0] x1, x2, x3;
    x1 = a + b;
    x2 = c - d;
    x3 = x1 + x2;
    return {{W{1'b0}}, x3} * {{W{1'b0}}, d};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Evaluate both handshakes just before the coming edge, then advance one cycle.
  task automatic cyc();
    bit pop;
    #1;
    pop = out_valid && out_ready;
    if (in_valid && in_ready) begin
      q.push_back(use_tab ? tab_f : ref_f(A, B, C, D));
      nacc++;
    end
    if (pop) begin
      npop++;
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk("F", F, q.pop_front());
      end
      run = prevpop ? run + 1 : 1;
      if (run > maxrun) maxrun = run;
    end
    prevpop = pop;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_ops();
    A = W'($urandom_range(0, 1023));
    B = W'($urandom_range(0, 1023));
    C = W'($urandom_range(0, 1023));
    D = W'($urandom_range(0, 1023));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || busy); i++) begin
      rnd_ops();
      cyc();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{10'd3,    10'd4,    10'd10,   10'd2,    20'd30};
    tab[1] = '{10'd1023, 10'd1,    10'd0,    10'd1,    20'd1023};
    tab[2] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 20'd1045506};
    tab[3] = '{10'd0,    10'd0,    10'd0,    10'd0,    20'd0};
    tab[4] = '{10'd5,    10'd0,    10'd0,    10'd7,    20'd7154};
    tab[5] = '{10'd100,  10'd200,  10'd50,   10'd3,    20'd1041};
    tab[6] = '{10'd512,  10'd512,  10'd9,    10'd0,    20'd0};
    tab[7] = '{10'd1,    10'd2,    10'd3,    10'd1,    20'd5};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; C = '0; D = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_F", F, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single accept: out_valid must be seen exactly on the third edge.
    A = 10'd3; B = 10'd4; C = 10'd10; D = 10'd2;
    in_valid = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1 chk($sformatf("lat_edge%0d", k), out_valid, k == 3);
      cyc();
    end
    chk("lat_pops", npop, 1);

    // Table vectors back to back.
    a0 = nacc; maxrun = 0;
    use_tab = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = tab[i].a; B = tab[i].b; C = tab[i].c; D = tab[i].d;
      tab_f = tab[i].f;
      in_valid = 1'b1;
      cyc();
    end
    use_tab = 1'b0;
    drain();
    chk("tab_accepts", nacc - a0, 8);
    chk("tab_run", maxrun, 8);

    // Random burst of 8: results on 8 consecutive cycles.
    a0 = nacc; p0 = npop; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      rnd_ops();
      in_valid = 1'b1;
      cyc();
    end
    drain();
    chk("burst_accepts", nacc - a0, 8);
    chk("burst_pops", npop - p0, 8);
    chk("burst_run", maxrun, 8);

    // Backpressure: three accepts then stall with F held.
    a0 = nacc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rnd_ops();
      cyc();
    end
    chk("bp_accepts", nacc - a0, 3);
    #1 chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    hold_f = F;
    for (int i = 0; i < 2; i++) begin
      rnd_ops();
      cyc();
      #1 chk("bp_F_stable", F, hold_f);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 chk("bp_ready_rise", in_ready, 1);
    p0 = npop;
    drain();
    chk("bp_pops", npop - p0, 3);

    // Flush with three in flight and in_valid held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd_ops();
      cyc();
    end
    flush = 1'b1;
    rnd_ops();
    #1 chk("flush_in_ready", in_ready, 0);
    a0 = nacc;
    cyc();
    chk("flush_no_accept", nacc - a0, 0);
    q.delete();
    flush = 1'b0;
    in_valid = 1'b0;
    #1 chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    A = 10'd7; B = 10'd9; C = 10'd20; D = 10'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    p0 = npop;
    cyc();
    drain();
    chk("flush_fresh_pops", npop - p0, 1);

    // Async reset between edges with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rnd_ops();
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("ar_busy_before", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_F", F, 0);
    chk("ar_busy", busy, 0);
    chk("ar_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = npop;
    for (int i = 0; i < 6; i++) begin
      rnd_ops();
      cyc();
    end
    chk("ar_no_stale", npop - p0, 0);
    rnd_ops();
    in_valid = 1'b1;
    cyc();
    drain();
    chk("ar_fresh_pops", npop - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
